// File: rtl/pulse_train_gen.sv
// Programmable pulse train generator: emits num_pulses high pulses of high_len cycles
// separated by low_len cycles, reporting busy, done and the number of falling edges emitted.
module pulse_train_gen #(
  parameter int CNT_W = 8,
  parameter int NUM_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] high_len,
  input  logic [CNT_W-1:0] low_len,
  input  logic [NUM_W-1:0] num_pulses,
  output logic             pulse_out,
  output logic             busy,
  output logic             done,
  output logic [NUM_W-1:0] fall_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    HIGH,
    LOW
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] timer;
  logic [CNT_W-1:0] high_len_q;
  logic [CNT_W-1:0] low_len_q;
  logic [NUM_W-1:0] remaining;

  // The timer holds cycles left after the current one, so a zero length still
  // yields a single-cycle phase.
  function automatic logic [CNT_W-1:0] phase_load(input logic [CNT_W-1:0] len);
    return (len == '0) ? '0 : len - CNT_W'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      pulse_out  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      fall_cnt   <= '0;
      timer      <= '0;
      high_len_q <= '0;
      low_len_q  <= '0;
      remaining  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !abort) begin
            fall_cnt <= '0;
            if (num_pulses != '0) begin
              state      <= HIGH;
              pulse_out  <= 1'b1;
              busy       <= 1'b1;
              high_len_q <= high_len;
              low_len_q  <= low_len;
              remaining  <= num_pulses;
              timer      <= phase_load(high_len);
            end else begin
              done <= 1'b1;
            end
          end
        end

        // Abort takes priority over the natural end of a phase, and the edge it
        // forces while high is still a real falling edge downstream.
        HIGH: begin
          if (abort) begin
            state     <= IDLE;
            pulse_out <= 1'b0;
            busy      <= 1'b0;
            fall_cnt  <= fall_cnt + NUM_W'(1);
          end else if (timer != '0) begin
            timer <= timer - CNT_W'(1);
          end else begin
            pulse_out <= 1'b0;
            fall_cnt  <= fall_cnt + NUM_W'(1);
            remaining <= remaining - NUM_W'(1);
            if (remaining == NUM_W'(1)) begin
              state <= IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state <= LOW;
              timer <= phase_load(low_len_q);
            end
          end
        end

        LOW: begin
          if (abort) begin
            state     <= IDLE;
            pulse_out <= 1'b0;
            busy      <= 1'b0;
          end else if (timer != '0) begin
            timer <= timer - CNT_W'(1);
          end else begin
            state     <= HIGH;
            pulse_out <= 1'b1;
            timer     <= phase_load(high_len_q);
          end
        end

        default: begin
          state     <= IDLE;
          pulse_out <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pulse_train_gen.sv
// Self-checking bench for pulse_train_gen: scenario tasks compare every cycle against
// a waveform model built by expanding the train into a list of per-cycle levels.
module tb_pulse_train_gen;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       abort;
  logic [7:0] high_len;
  logic [7:0] low_len;
  logic [7:0] num_pulses;
  logic       pulse_out;
  logic       busy;
  logic       done;
  logic [7:0] fall_cnt;

  int errors = 0;
  int checks = 0;
  int last_fall = 0;

  int exp_pulse[$];
  int exp_busy[$];
  int exp_done[$];
  int exp_fall[$];

  always #5 clk = ~clk;

  pulse_train_gen #(.CNT_W(8), .NUM_W(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .abort      (abort),
    .high_len   (high_len),
    .low_len    (low_len),
    .num_pulses (num_pulses),
    .pulse_out  (pulse_out),
    .busy       (busy),
    .done       (done),
    .fall_cnt   (fall_cnt)
  );

  // Cycle c (1-based) is the clock period following the c-th edge after the start
  // edge. The train is written out as a flat list of levels; falls are the ends of
  // high runs. abort_at names the cycle during which abort is held (0 = none).
  function automatic void build_model(input int h, input int l, input int n,
                                      input int abort_at, input int total);
    int wave[$];
    int hh;
    int ll;
    int len;
    int falls;
    hh = (h == 0) ? 1 : h;
    ll = (l == 0) ? 1 : l;
    exp_pulse.delete(); exp_busy.delete(); exp_done.delete(); exp_fall.delete();
    for (int p = 0; p < n; p++) begin
      for (int k = 0; k < hh; k++) wave.push_back(1);
      if (p < n - 1) for (int k = 0; k < ll; k++) wave.push_back(0);
    end
    len = wave.size();
    for (int c = 1; c <= total; c++) begin
      int lim;
      lim = (abort_at > 0 && c > abort_at) ? abort_at : c - 1;
      if (lim > len) lim = len;
      falls = 0;
      for (int j = 1; j <= lim; j++)
        if (wave[j-1] == 1 && (j == len || wave[j] == 0)) falls++;
      if (abort_at > 0 && c > abort_at) begin
        if (wave[abort_at-1] == 1 && !(abort_at == len || wave[abort_at] == 0)) falls++;
        exp_pulse.push_back(0); exp_busy.push_back(0); exp_done.push_back(0);
        exp_fall.push_back(falls);
      end else if (c <= len) begin
        exp_pulse.push_back(wave[c-1]); exp_busy.push_back(1); exp_done.push_back(0);
        exp_fall.push_back(falls);
      end else begin
        exp_pulse.push_back(0); exp_busy.push_back(0);
        exp_done.push_back((c == len + 1) ? 1 : 0);
        exp_fall.push_back(n % 256);
      end
    end
  endfunction

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    start = 1'($urandom); abort = 1'($urandom);
    high_len = 8'($urandom); low_len = 8'($urandom); num_pulses = 8'($urandom);
    @(negedge clk);
    start = 1'($urandom); num_pulses = 8'($urandom);
    @(negedge clk);
    checks++; if (pulse_out !== 1'b0) begin errors++; $display("[TB] FAIL reset_pulse got=%b want=0", pulse_out); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got=%b want=0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done got=%b want=0", done); end
    checks++; if (fall_cnt !== 8'd0) begin errors++; $display("[TB] FAIL reset_fall got=%0d want=0", fall_cnt); end
    reset = 1'b0; start = 1'b0; abort = 1'b0;
    last_fall = 0;
  endtask

  // Literal waveform for high=2, low=3, two pulses.
  task automatic test_basic();
    int ep[8] = '{1, 1, 0, 0, 0, 1, 1, 0};
    int eb[8] = '{1, 1, 1, 1, 1, 1, 1, 0};
    int ed[8] = '{0, 0, 0, 0, 0, 0, 0, 1};
    int ef[8] = '{0, 0, 1, 1, 1, 1, 1, 2};
    @(negedge clk);
    high_len = 8'd2; low_len = 8'd3; num_pulses = 8'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 8; c++) begin
      checks++; if (pulse_out !== 1'(ep[c])) begin errors++; $display("[TB] FAIL basic_pulse c=%0d got=%b want=%0d", c+1, pulse_out, ep[c]); end
      checks++; if (busy !== 1'(eb[c])) begin errors++; $display("[TB] FAIL basic_busy c=%0d got=%b want=%0d", c+1, busy, eb[c]); end
      checks++; if (done !== 1'(ed[c])) begin errors++; $display("[TB] FAIL basic_done c=%0d got=%b want=%0d", c+1, done, ed[c]); end
      checks++; if (fall_cnt !== 8'(ef[c])) begin errors++; $display("[TB] FAIL basic_fall c=%0d got=%0d want=%0d", c+1, fall_cnt, ef[c]); end
      @(negedge clk);
    end
    last_fall = 2;
  endtask

  // Shared shape for model-driven scenarios: start a train, optionally abort or
  // poke a spurious start, scramble the timing inputs, and compare every cycle.
  task automatic test_train(input string name, input int h, input int l, input int n,
                            input int abort_at, input int spur_at, input int total);
    int len;
    len = (n == 0) ? 0 : n * ((h == 0) ? 1 : h) + (n - 1) * ((l == 0) ? 1 : l);
    build_model(h, l, n, abort_at, total);
    @(negedge clk);
    high_len = 8'(h); low_len = 8'(l); num_pulses = 8'(n); start = 1'b1; abort = 1'b0;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= total; c++) begin
      checks++; if (pulse_out !== 1'(exp_pulse[c-1])) begin errors++; $display("[TB] FAIL %s_pulse c=%0d got=%b want=%0d", name, c, pulse_out, exp_pulse[c-1]); end
      checks++; if (busy !== 1'(exp_busy[c-1])) begin errors++; $display("[TB] FAIL %s_busy c=%0d got=%b want=%0d", name, c, busy, exp_busy[c-1]); end
      checks++; if (done !== 1'(exp_done[c-1])) begin errors++; $display("[TB] FAIL %s_done c=%0d got=%b want=%0d", name, c, done, exp_done[c-1]); end
      checks++; if (fall_cnt !== 8'(exp_fall[c-1])) begin errors++; $display("[TB] FAIL %s_fall c=%0d got=%0d want=%0d", name, c, fall_cnt, exp_fall[c-1]); end
      abort = (c == abort_at);
      start = (c == spur_at && c <= len && (abort_at == 0 || c <= abort_at));
      high_len = 8'($urandom); low_len = 8'($urandom); num_pulses = 8'($urandom_range(1, 255));
      @(negedge clk);
    end
    abort = 1'b0; start = 1'b0;
    last_fall = exp_fall[total-1];
  endtask

  task automatic test_empty();
    test_train("empty", 3, 3, 0, 0, 0, 4);
  endtask

  task automatic test_zero_len();
    test_train("zerolen", 0, 0, 3, 0, 2, 8);
  endtask

  // Third HIGH begins at cycle 13, so its second cycle is 14.
  task automatic test_abort();
    test_train("abort", 4, 2, 5, 14, 5, 18);
  endtask

  task automatic test_start_abort_idle();
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      high_len = 8'd2; low_len = 8'd2; num_pulses = (k == 0) ? 8'd3 : 8'd0;
      start = 1'b1; abort = 1'b1;
      @(negedge clk);
      start = 1'b0; abort = 1'b0;
      checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL idleabort_busy k=%0d got=%b want=0", k, busy); end
      checks++; if (pulse_out !== 1'b0) begin errors++; $display("[TB] FAIL idleabort_pulse k=%0d got=%b want=0", k, pulse_out); end
      checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL idleabort_done k=%0d got=%b want=0", k, done); end
      checks++; if (fall_cnt !== 8'(last_fall)) begin errors++; $display("[TB] FAIL idleabort_fall k=%0d got=%0d want=%0d", k, fall_cnt, last_fall); end
    end
  endtask

  // Four pulses of high=3/low=2: second HIGH spans cycles 6..8, reset during 7.
  task automatic test_reset_midtrain();
    build_model(3, 2, 4, 0, 7);
    @(negedge clk);
    high_len = 8'd3; low_len = 8'd2; num_pulses = 8'd4; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      checks++; if (pulse_out !== 1'(exp_pulse[c-1])) begin errors++; $display("[TB] FAIL midreset_pulse c=%0d got=%b want=%0d", c, pulse_out, exp_pulse[c-1]); end
      checks++; if (fall_cnt !== 8'(exp_fall[c-1])) begin errors++; $display("[TB] FAIL midreset_fall c=%0d got=%0d want=%0d", c, fall_cnt, exp_fall[c-1]); end
      if (c == 7) reset = 1'b1;
      @(negedge clk);
    end
    reset = 1'b0;
    checks++; if (pulse_out !== 1'b0) begin errors++; $display("[TB] FAIL midreset_pulse_after got=%b want=0", pulse_out); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL midreset_busy_after got=%b want=0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL midreset_done_after got=%b want=0", done); end
    checks++; if (fall_cnt !== 8'd0) begin errors++; $display("[TB] FAIL midreset_fall_after got=%0d want=0", fall_cnt); end
    last_fall = 0;
    test_train("postreset", 2, 1, 4, 0, 0, 16);
  endtask

  task automatic test_random();
    for (int t = 0; t < 12; t++) begin
      int h, l, n, len, a, s;
      h = $urandom_range(0, 4);
      l = $urandom_range(0, 4);
      n = $urandom_range(0, 5);
      len = (n == 0) ? 0 : n * ((h == 0) ? 1 : h) + (n - 1) * ((l == 0) ? 1 : l);
      a = (n > 0 && $urandom_range(0, 2) == 0) ? $urandom_range(1, len) : 0;
      s = (len > 0) ? $urandom_range(1, len) : 0;
      test_train("random", h, l, n, a, s, ((a > 0) ? a : len) + 3);
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0;
    high_len = '0; low_len = '0; num_pulses = '0;
    test_reset();
    test_basic();
    test_empty();
    test_zero_len();
    test_abort();
    test_start_abort_idle();
    test_reset_midtrain();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
